// File: rtl/gate_pipe_unit_pkg.sv
// Shared definitions for the gate pipeline: op codes, legal-range checks and
// the bitwise gate evaluation used by the top level.
package gate_pkg;

  localparam int MAXW = 64;
  localparam int MAXN = 4;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  function automatic bit width_ok(int w);
    return (w >= 1) && (w <= MAXW);
  endfunction

  function automatic bit nin_ok(int nin);
    return (nin >= 2) && (nin <= MAXN);
  endfunction

  function automatic bit depth_ok(int d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

  // Operands beyond nin are skipped so NIN-operand reductions stay exact.
  function automatic logic [MAXW-1:0] gate_eval(op_e op,
                                                logic [MAXN-1:0][MAXW-1:0] opnd,
                                                int nin);
    logic [MAXW-1:0] acc_and;
    logic [MAXW-1:0] acc_or;
    logic [MAXW-1:0] acc_xor;
    logic [MAXW-1:0] res;
    acc_and = '1;
    acc_or  = '0;
    acc_xor = '0;
    for (int k = 0; k < MAXN; k++) begin
      if (k < nin) begin
        acc_and = acc_and & opnd[k];
        acc_or  = acc_or  | opnd[k];
        acc_xor = acc_xor ^ opnd[k];
      end
    end
    case (op)
      OP_AND:  res = acc_and;
      OP_NAND: res = ~acc_and;
      OP_OR:   res = acc_or;
      OP_NOR:  res = ~acc_or;
      OP_XOR:  res = acc_xor;
      OP_XNOR: res = ~acc_xor;
      OP_NOT:  res = ~opnd[0];
      default: res = opnd[0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_pipe_unit_if.sv
// Valid/ready request and response channels of the gate pipeline.
interface gate_pipe_unit_if #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [NIN*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [2:0]           out_op;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_op
  );
endinterface

// File: rtl/gate_pipe_unit_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head reads as zero when empty
// so consumers never see stale entries.
module gate_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/gate_pipe_unit.sv
// Pipelined multi-operand bitwise gate: evaluates on accept, queues {op, result}
// in a small FIFO and counts popped results.
module gate_pipe_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_pipe_unit_if.slave bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 3 + WIDTH;

  if (!(width_ok(WIDTH) && nin_ok(NIN) && depth_ok(DEPTH))) begin : g_bad_cfg
    $error("gate_pipe_unit: WIDTH, NIN or DEPTH out of range");
  end

  logic [MAXN-1:0][MAXW-1:0] operands_w;
  logic [MAXW-1:0]           result_full_w;
  logic [WIDTH-1:0]          result_w;
  logic [DW-1:0]             head_w;
  logic [AW:0]               occupancy;
  logic                      fifo_full, fifo_empty;
  logic                      push_w, pop_w;
  logic                      ready_en_q;
  logic [CNTW-1:0]           op_count_q, op_count_d;

  for (genvar gi = 0; gi < MAXN; gi++) begin : g_opnd
    if (gi < NIN) begin : g_used
      assign operands_w[gi] = MAXW'(bus.in_data[gi*WIDTH +: WIDTH]);
    end else begin : g_idle
      assign operands_w[gi] = '0;
    end
  end

  assign result_full_w = gate_eval(op_e'(bus.in_op), operands_w, NIN);
  assign result_w      = result_full_w[WIDTH-1:0];

  if (WIDTH < MAXW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^result_full_w[MAXW-1:WIDTH];
  end

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign bus.in_ready  = ready_en_q && !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign push_w        = bus.in_valid && bus.in_ready;
  assign pop_w         = bus.out_valid && bus.out_ready;

  gate_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_w),
    .wdata_i ({bus.in_op, result_w}),
    .pop_i   (pop_w),
    .rdata_o (head_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  assign bus.out_op   = head_w[DW-1:WIDTH];
  assign bus.out_data = head_w[WIDTH-1:0];
  assign busy         = |occupancy;

  always_comb begin
    op_count_d = op_count_q;
    if (pop_w) op_count_d = op_count_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count_q <= '0;
    else        op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
endmodule

// File: tb/tb_gate_pipe_unit.sv
// Randomised self-checking bench for gate_pipe_unit: a NIN=2/DEPTH=2 instance
// against a queue model, plus a NIN=3/DEPTH=4/CNTW=4 instance.
module tb_gate_pipe_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n;
  logic        busy0, busy1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  gate_pipe_unit_if #(.WIDTH(8), .NIN(2)) bus0 ();
  gate_pipe_unit_if #(.WIDTH(8), .NIN(3)) bus1 ();

  gate_pipe_unit #(.WIDTH(8), .NIN(2), .DEPTH(2), .CNTW(16)) dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0), .busy(busy0), .op_count(cnt0));
  gate_pipe_unit #(.WIDTH(8), .NIN(3), .DEPTH(4), .CNTW(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1), .busy(busy1), .op_count(cnt1));

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] mq [$];
  logic [15:0] m_cnt;
  bit          m_init;

  // Per bit: count the ones among the n operands and apply the gate's rule.
  function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c,
                                          input int n);
    logic [7:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      ones = int'(a[i]) + int'(b[i]) + ((n > 2) ? int'(c[i]) : 0);
      case (op)
        0: r[i] = (ones == n);
        1: r[i] = (ones != n);
        2: r[i] = (ones > 0);
        3: r[i] = (ones == 0);
        4: r[i] = (ones % 2 == 1);
        5: r[i] = (ones % 2 == 0);
        6: r[i] = ~a[i];
        default: r[i] = a[i];
      endcase
    end
    return r;
  endfunction

  // One clock of dut0: drive, advance the model, compare every output.
  task automatic step0(input bit v, input logic [2:0] op, input logic [15:0] d, input bit ordy);
    bit acc, pop, exp_v;
    logic [10:0] exp_head;
    @(negedge clk);
    bus0.in_valid  = v;
    bus0.in_op     = op;
    bus0.in_data   = d;
    bus0.out_ready = ordy;
    acc = v && m_init && (mq.size() < 2);
    pop = ordy && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (acc) mq.push_back({op, ref_gate(int'(op), d[7:0], d[15:8], 8'h00, 2)});
    m_init = 1'b1;
    exp_v    = (mq.size() != 0);
    exp_head = exp_v ? mq[0] : 11'h000;
    n_tests++;
    if (bus0.out_valid !== exp_v || busy0 !== exp_v) begin
      n_fail++;
      $display("FAIL step_valid got valid=%b busy=%b want %b", bus0.out_valid, busy0, exp_v);
    end
    n_tests++;
    if ({bus0.out_op, bus0.out_data} !== exp_head) begin
      n_fail++;
      $display("FAIL step_head got op=%0d data=%h want op=%0d data=%h",
               bus0.out_op, bus0.out_data, exp_head[10:8], exp_head[7:0]);
    end
    n_tests++;
    if (bus0.in_ready !== (mq.size() < 2)) begin
      n_fail++;
      $display("FAIL step_in_ready got %b want %b", bus0.in_ready, (mq.size() < 2));
    end
    n_tests++;
    if (cnt0 !== m_cnt) begin
      n_fail++;
      $display("FAIL step_op_count got %0d want %0d", cnt0, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.in_valid = 0; bus0.in_op = 0; bus0.in_data = 0; bus0.out_ready = 0;
    bus1.in_valid = 0; bus1.in_op = 0; bus1.in_data = 0; bus1.out_ready = 0;
    mq.delete();
    m_cnt  = 0;
    m_init = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus0.out_valid, busy0, bus0.in_ready, cnt0, bus0.out_data} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_dut0 got valid=%b busy=%b rdy=%b cnt=%0d data=%h want all 0",
               bus0.out_valid, busy0, bus0.in_ready, cnt0, bus0.out_data);
    end
    n_tests++;
    if ({bus1.out_valid, busy1, bus1.in_ready, cnt1} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_dut1 got valid=%b busy=%b rdy=%b cnt=%0d want all 0",
               bus1.out_valid, busy1, bus1.in_ready, cnt1);
    end
    @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    #1;
    n_tests++;
    if (bus0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge got %b want 0", bus0.in_ready);
    end
    @(posedge clk);
    #1;
    m_init = 1'b1;
    n_tests++;
    if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge got %b/%b want 1/1", bus0.in_ready, bus1.in_ready);
    end
  endtask

  task automatic test_single_ops();
    logic [7:0] exp_tab [8] = '{8'hC0, 8'h3F, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    for (int op = 0; op < 8; op++) begin
      step0(1'b1, 3'(op), {8'hCC, 8'hF0}, 1'b1);
      n_tests++;
      if (bus0.out_data !== exp_tab[op] || bus0.out_op !== 3'(op)) begin
        n_fail++;
        $display("FAIL single_op%0d got op=%0d data=%h want %h", op, bus0.out_op, bus0.out_data, exp_tab[op]);
      end
    end
    step0(1'b0, 3'd0, 16'h0000, 1'b1);
    n_tests++;
    if (cnt0 !== 16'd8) begin
      n_fail++;
      $display("FAIL single_count got %0d want 8", cnt0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) step0(1'b1, 3'd1, {8'hCC, 8'hF0}, 1'b0);
    n_tests++;
    if (bus0.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_ready got %b want 0", bus0.in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step0(1'b0, 3'd0, 16'h0000, 1'b0);
      n_tests++;
      if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h3F) begin
        n_fail++;
        $display("FAIL bp_hold got valid=%b data=%h want 1 3f", bus0.out_valid, bus0.out_data);
      end
    end
    step0(1'b1, 3'd1, {8'hCC, 8'hF0}, 1'b1);
    n_tests++;
    if (bus0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready got %b want 1", bus0.in_ready);
    end
    repeat (3) step0(1'b0, 3'd0, 16'h0000, 1'b1);
  endtask

  task automatic test_push_pop_occ1();
    step0(1'b1, 3'($urandom_range(7)), 16'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step0(1'b1, 3'($urandom_range(7)), 16'($urandom), 1'b1);
      n_tests++;
      if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL occ1_steady got valid=%b rdy=%b want 1 1", bus0.out_valid, bus0.in_ready);
      end
    end
    repeat (2) step0(1'b0, 3'd0, 16'h0000, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      step0(1'($urandom), 3'($urandom_range(7)), 16'($urandom), ($urandom_range(3) != 0));
    repeat (3) step0(1'b0, 3'd0, 16'h0000, 1'b1);
  endtask

  task automatic test_async_reset();
    step0(1'b1, 3'd2, 16'($urandom), 1'b1);
    repeat (2) step0(1'b1, 3'd2, 16'($urandom), 1'b0);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst0_n = 1'b0;
    mq.delete();
    m_cnt  = 0;
    m_init = 0;
    #1;
    n_tests++;
    if ({bus0.out_valid, busy0, bus0.in_ready, cnt0, bus0.out_data} !== 27'd0) begin
      n_fail++;
      $display("FAIL async_reset got valid=%b busy=%b rdy=%b cnt=%0d data=%h want all 0",
               bus0.out_valid, busy0, bus0.in_ready, cnt0, bus0.out_data);
    end
    @(negedge clk);
    rst0_n = 1'b1;
    @(posedge clk);
    #1;
    m_init = 1'b1;
    step0(1'b1, 3'd4, 16'hA55A, 1'b0);
    n_tests++;
    if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hFF) begin
      n_fail++;
      $display("FAIL post_reset_xor got valid=%b data=%h want 1 ff", bus0.out_valid, bus0.out_data);
    end
    step0(1'b0, 3'd0, 16'h0000, 1'b1);
  endtask

  task automatic test_nin3();
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_op = 3'd4; bus1.in_data = {8'h01, 8'h0F, 8'hFF}; bus1.out_ready = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'hF1) begin
      n_fail++;
      $display("FAIL nin3_xor got valid=%b data=%h want 1 f1", bus1.out_valid, bus1.out_data);
    end
    @(negedge clk);
    bus1.in_op = 3'd1;
    @(posedge clk); #1;
    n_tests++;
    if (bus1.out_data !== 8'hF1) begin
      n_fail++;
      $display("FAIL nin3_hold got %h want f1", bus1.out_data);
    end
    @(negedge clk);
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus1.out_data !== 8'hFE || bus1.out_op !== 3'd1) begin
      n_fail++;
      $display("FAIL nin3_nand got op=%0d data=%h want 1 fe", bus1.out_op, bus1.out_data);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus1.out_valid !== 1'b0 || cnt1 !== 4'd2) begin
      n_fail++;
      $display("FAIL nin3_drain got valid=%b cnt=%0d want 0 2", bus1.out_valid, cnt1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q1 [$];
    logic [7:0] exp_d;
    logic [23:0] d;
    logic [2:0]  op;
    int pushed = 0;
    bus1.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !(pushed == 15 && q1.size() == 0); cyc++) begin
      @(negedge clk);
      if (bus1.out_valid === 1'b1) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_extra got data=%h want no result", bus1.out_data);
        end else begin
          exp_d = q1.pop_front();
          if (bus1.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL wrap_data got %h want %h", bus1.out_data, exp_d);
          end
        end
      end
      if (pushed < 15 && bus1.in_ready === 1'b1) begin
        d  = 24'($urandom);
        op = 3'($urandom_range(7));
        bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_data = d;
        q1.push_back(ref_gate(int'(op), d[7:0], d[15:8], d[23:16], 3));
        pushed++;
      end else begin
        bus1.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    n_tests++;
    if (!(pushed == 15 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL wrap_timeout got pushed=%0d pending=%0d want 15 0", pushed, q1.size());
    end
    n_tests++;
    if (cnt1 !== 4'd1 || bus1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count got cnt=%0d valid=%b want 1 0", cnt1, bus1.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_backpressure();
    test_push_pop_occ1();
    test_random();
    test_async_reset();
    test_nin3();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
